// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Values shared between the text frame buffer and the LCD driver:
//   - command opcodes carried on cmd_op
//   - the blank character used to fill the frame
//   - DDRAM line base addresses the driver prefixes to each line
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [1:0] OP_PUT   = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_HOME  = 2'b11;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    localparam logic [7:0] DDRAM_LINE1 = 8'h80;
    localparam logic [7:0] DDRAM_LINE2 = 8'hC0;

endpackage

// File: rtl/lcd_text_buffer_if.sv
// -----------------------------------------------------------------------------
// lcd_text_buffer_if
// Cursor-based command port of the text frame buffer.
//   cmd_valid : command offered by the writer
//   cmd_ready : buffer accepts when cmd_valid & cmd_ready
//   cmd_op    : PUT / SET / CLEAR / HOME (see lcd_pkg)
//   cmd_data  : character code (PUT) or cursor position (SET)
// master = game/control logic, slave = lcd_text_buffer.
// -----------------------------------------------------------------------------
interface lcd_text_buffer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/lcd_char_ram.sv
// -----------------------------------------------------------------------------
// lcd_char_ram
// DEPTH x 8 character store, one write port and one registered read port.
// A read and write to the same address in one cycle returns the old value.
// Ports:
//   clk, resetn : clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : read port, rdata valid one cycle after raddr
// -----------------------------------------------------------------------------
module lcd_char_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    // Array is left unreset so it maps onto plain RAM; contents are
    // initialised by the owner's clearing pass.
    logic [7:0] mem_r [DEPTH];
    logic [7:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; sampling before the write lands gives read-before-write
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rdata_r <= 8'h00;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/lcd_text_buffer.sv
// -----------------------------------------------------------------------------
// lcd_text_buffer
// ROWS x COLS character frame buffer sitting upstream of the text LCD driver.
// Ports:
//   clk, resetn  : clock, asynchronous active-high reset
//   cmd          : command port (slave side of lcd_text_buffer_if)
//   cursor       : current write position, row = MSB, col = low bits
//   rd_addr      : driver read address
//   rd_data      : character at rd_addr, one cycle later
//   frame_dirty  : frame changed since the last frame_ack
//   frame_req    : redraw request, suppressed while the frame is being cleared
//   frame_ack    : single-cycle pulse from the driver when a redraw starts
// After reset the buffer fills itself with CLR_CHAR (32 cycles) before
// accepting commands; that initial fill does not raise frame_dirty.
// -----------------------------------------------------------------------------
module lcd_text_buffer
    import lcd_pkg::*;
#(
    parameter int         COLS     = 16,
    parameter int         ROWS     = 2,
    parameter logic [7:0] CLR_CHAR = CHAR_SPACE,
    localparam int        ADDR_W   = $clog2(COLS * ROWS)
) (
    input  logic                clk,
    input  logic                resetn,
    lcd_text_buffer_if.slave    cmd,
    output logic [ADDR_W-1:0]   cursor,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [7:0]          rd_data,
    output logic                frame_dirty,
    output logic                frame_req,
    input  logic                frame_ack
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_CLEARING = 1'b1;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);

    logic [0:0]        state_r,  state_s;
    logic [ADDR_W-1:0] cursor_r, cursor_s;
    logic [ADDR_W-1:0] clr_ptr_r, clr_ptr_s;
    logic              dirty_r,  dirty_s;
    logic              req_r,    req_s;
    logic              ready_r,  ready_s;
    logic              boot_r,   boot_s;    // high until the post-reset fill completes

    logic              clearing_s;
    logic              accept_s;
    logic              put_s;
    logic              clr_last_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [7:0]        ram_wdata_s;

    // Next-state, cursor, dirty and RAM write control
    always_comb begin
        state_s    = state_r;
        cursor_s   = cursor_r;
        clr_ptr_s  = clr_ptr_r;
        boot_s     = boot_r;
        put_s      = 1'b0;
        clr_last_s = 1'b0;
        clearing_s = (state_r == ST_CLEARING);
        accept_s   = cmd.cmd_valid & (state_r == ST_IDLE);

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd.cmd_op)
                        OP_PUT: begin
                            // Power-of-two depth: natural overflow gives
                            // row0 col15 -> row1 col0 -> ... -> row0 col0
                            cursor_s = cursor_r + ADDR_W'(1);
                            put_s    = 1'b1;
                        end
                        OP_SET: begin
                            cursor_s = cmd.cmd_data[ADDR_W-1:0];
                        end
                        OP_CLEAR: begin
                            state_s   = ST_CLEARING;
                            clr_ptr_s = '0;
                        end
                        OP_HOME: begin
                            cursor_s = '0;
                        end
                        default: begin
                            cursor_s = cursor_r;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEARING: begin
                clr_ptr_s = clr_ptr_r + ADDR_W'(1);
                if (clr_ptr_r == CLR_LAST) begin
                    clr_last_s = 1'b1;
                    state_s    = ST_IDLE;
                    cursor_s   = '0;
                    boot_s     = 1'b0;
                end else begin
                    state_s = ST_CLEARING;
                end
            end
            default: begin
                state_s   = ST_CLEARING;
                clr_ptr_s = '0;
            end
        endcase

        // A change to the frame outranks a simultaneous acknowledge
        if (put_s || (clr_last_s && !boot_r)) begin
            dirty_s = 1'b1;
        end else if (frame_ack) begin
            dirty_s = 1'b0;
        end else begin
            dirty_s = dirty_r;
        end

        ready_s = (state_s == ST_IDLE);
        req_s   = dirty_s & (state_s != ST_CLEARING);

        ram_we_s = put_s | clearing_s;
        if (clearing_s) begin
            ram_waddr_s = clr_ptr_r;
            ram_wdata_s = CLR_CHAR;
        end else begin
            ram_waddr_s = cursor_r;
            ram_wdata_s = cmd.cmd_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r   <= ST_CLEARING;
            cursor_r  <= '0;
            clr_ptr_r <= '0;
            dirty_r   <= 1'b0;
            req_r     <= 1'b0;
            ready_r   <= 1'b0;
            boot_r    <= 1'b1;
        end else begin
            state_r   <= state_s;
            cursor_r  <= cursor_s;
            clr_ptr_r <= clr_ptr_s;
            dirty_r   <= dirty_s;
            req_r     <= req_s;
            ready_r   <= ready_s;
            boot_r    <= boot_s;
        end
    end

    lcd_char_ram #(
        .DEPTH  (COLS * ROWS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we_s),
        .waddr  (ram_waddr_s),
        .wdata  (ram_wdata_s),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

    assign cmd.cmd_ready = ready_r;
    assign cursor        = cursor_r;
    assign frame_dirty   = dirty_r;
    assign frame_req     = req_r;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_buffer
// Directed self-checking bench for lcd_text_buffer (2 x 16, clear char 8'h20).
// Inputs change and outputs are sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_lcd_text_buffer;
    import lcd_pkg::*;

    logic       clk;
    logic       resetn;
    logic [4:0] cursor;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_dirty;
    logic       frame_req;
    logic       frame_ack;

    int checks;
    int failures;

    lcd_text_buffer_if cmd_if ();

    lcd_text_buffer dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd         (cmd_if),
        .cursor      (cursor),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_dirty (frame_dirty),
        .frame_req   (frame_req),
        .frame_ack   (frame_ack)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
        int waits;
        waits = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        while (!cmd_if.cmd_ready && waits < 100) begin
            tick();
            waits++;
        end
        check_eq("cmd_ready_wait", 32'(cmd_if.cmd_ready), 32'd1);
        tick();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        tick();
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    // Counts edges until cmd_ready rises (bounded)
    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_if.cmd_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic req_seen;
        logic dirty_lost;

        checks           = 0;
        failures         = 0;
        resetn           = 1'b1;
        frame_ack        = 1'b0;
        rd_addr          = 5'd0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_PUT;
        cmd_if.cmd_data  = 8'h00;

        // ---- reset state and post-reset fill ----
        repeat (3) tick();
        check_eq("rst_ready",  32'(cmd_if.cmd_ready), 32'd0);
        check_eq("rst_cursor", 32'(cursor),           32'd0);
        check_eq("rst_rdata",  32'(rd_data),          32'h00);
        check_eq("rst_dirty",  32'(frame_dirty),      32'd0);
        check_eq("rst_req",    32'(frame_req),        32'd0);
        resetn = 1'b0;
        wait_ready(n);
        check_eq("boot_clear_len", 32'(n),           32'd32);
        check_eq("boot_dirty",     32'(frame_dirty), 32'd0);
        check_eq("boot_req",       32'(frame_req),   32'd0);
        check_eq("boot_cursor",    32'(cursor),      32'd0);
        for (int a = 0; a < 32; a++) begin
            read_chk("boot_mem", 5'(a), 8'h20);
        end

        // ---- PUT, read-back, ack ----
        send_cmd(OP_PUT, 8'h47);
        send_cmd(OP_PUT, 8'h41);
        read_chk("put_mem0", 5'd0, 8'h47);
        read_chk("put_mem1", 5'd1, 8'h41);
        check_eq("put_cursor", 32'(cursor),      32'd2);
        check_eq("put_dirty",  32'(frame_dirty), 32'd1);
        check_eq("put_req",    32'(frame_req),   32'd1);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_eq("ack_dirty", 32'(frame_dirty), 32'd0);
        check_eq("ack_req",   32'(frame_req),   32'd0);

        // ---- read-before-write on the write address ----
        rd_addr = 5'd2;
        send_cmd(OP_PUT, 8'h55);
        check_eq("rbw_old", 32'(rd_data), 32'h20);
        tick();
        check_eq("rbw_new", 32'(rd_data), 32'h55);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;

        // ---- SET / wrap / HOME ----
        send_cmd(OP_SET, 8'h0F);
        check_eq("set_cursor", 32'(cursor),      32'd15);
        check_eq("set_nodirty", 32'(frame_dirty), 32'd0);
        send_cmd(OP_PUT, 8'h21);
        send_cmd(OP_PUT, 8'h21);
        read_chk("row_wrap15", 5'd15, 8'h21);
        read_chk("row_wrap16", 5'd16, 8'h21);
        check_eq("row_wrap_cursor", 32'(cursor), 32'd17);
        send_cmd(OP_SET, 8'hFF);
        check_eq("set_mask_cursor", 32'(cursor), 32'd31);
        send_cmd(OP_PUT, 8'h58);
        read_chk("end_wrap_mem31", 5'd31, 8'h58);
        check_eq("end_wrap_cursor", 32'(cursor), 32'd0);
        send_cmd(OP_SET, 8'h07);
        send_cmd(OP_HOME, 8'h00);
        check_eq("home_cursor", 32'(cursor), 32'd0);

        // ---- ack coinciding with PUT: set wins ----
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_eq("pre_ack_dirty", 32'(frame_dirty), 32'd0);
        frame_ack = 1'b1;
        send_cmd(OP_PUT, 8'h33);
        frame_ack = 1'b0;
        check_eq("ack_put_dirty", 32'(frame_dirty), 32'd1);

        // ---- CLEAR with ack on the completion cycle ----
        send_cmd(OP_CLEAR, 8'h00);
        check_eq("clr_ready_drop", 32'(cmd_if.cmd_ready), 32'd0);
        n          = 0;
        req_seen   = 1'b0;
        dirty_lost = 1'b0;
        while (!cmd_if.cmd_ready && n < 100) begin
            req_seen   = req_seen | frame_req;
            dirty_lost = dirty_lost | ~frame_dirty;
            frame_ack  = (n == 31);
            tick();
            n++;
        end
        frame_ack = 1'b0;
        check_eq("clr_len",        32'(n),          32'd32);
        check_eq("clr_req_low",    32'(req_seen),   32'd0);
        check_eq("clr_dirty_held", 32'(dirty_lost), 32'd0);
        check_eq("clr_done_dirty", 32'(frame_dirty), 32'd1);
        check_eq("clr_done_req",   32'(frame_req),   32'd1);
        check_eq("clr_done_cursor", 32'(cursor),     32'd0);
        for (int a = 0; a < 32; a++) begin
            read_chk("clr_mem", 5'(a), 8'h20);
        end

        // ---- command held during CLEARING waits for cmd_ready ----
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        send_cmd(OP_CLEAR, 8'h00);
        check_eq("hold_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
        send_cmd(OP_PUT, 8'h77);
        check_eq("hold_cursor", 32'(cursor),      32'd1);
        check_eq("hold_dirty",  32'(frame_dirty), 32'd1);
        read_chk("hold_mem0", 5'd0, 8'h77);
        read_chk("hold_mem1", 5'd1, 8'h20);

        // ---- reset in the middle of a CLEAR ----
        send_cmd(OP_SET, 8'h14);
        send_cmd(OP_PUT, 8'hAA);
        read_chk("pre_rst_mem20", 5'd20, 8'hAA);
        send_cmd(OP_CLEAR, 8'h00);
        repeat (9) tick();
        resetn = 1'b1;
        #1;
        check_eq("mid_rst_cursor", 32'(cursor),           32'd0);
        check_eq("mid_rst_dirty",  32'(frame_dirty),      32'd0);
        check_eq("mid_rst_ready",  32'(cmd_if.cmd_ready), 32'd0);
        check_eq("mid_rst_rdata",  32'(rd_data),          32'h00);
        tick();
        tick();
        resetn = 1'b0;
        wait_ready(n);
        check_eq("re_clear_len",    32'(n),           32'd32);
        check_eq("re_clear_dirty",  32'(frame_dirty), 32'd0);
        check_eq("re_clear_req",    32'(frame_req),   32'd0);
        check_eq("re_clear_cursor", 32'(cursor),      32'd0);
        read_chk("re_clear_mem5",  5'd5,  8'h20);
        read_chk("re_clear_mem20", 5'd20, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
Character frame buffer directly upstream of the text LCD driver. Game and control logic write characters through a cursor-based command port. The LCD driver reads the 2x16 frame through a registered read port. A dirty/request/ack handshake tells the driver when a redraw is needed, replacing hard-coded line strings with run-time text.

Parameters:
COLS, 16, characters per line; power of two
ROWS, 2, display lines; power of two
CLR_CHAR, 8'h20, fill character used by CLEAR and after reset
ADDR_W, 5, log2(COLS*ROWS); derived, not overridden

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 PUT, 01 SET, 10 CLEAR, 11 HOME
cmd_data  in  8  PUT: character code; SET: cursor in bits [ADDR_W-1:0]; otherwise ignored
cursor  out  ADDR_W  current write position; row = MSB, col = low bits
rd_addr  in  ADDR_W  driver read address
rd_data  out  8  character at rd_addr, one cycle later
frame_dirty  out  1  buffer changed since the last ack
frame_req  out  1  redraw request = frame_dirty & ~clearing
frame_ack  in  1  single-cycle pulse; driver has begun redraw

Behaviour:
- Reset (resetn = 1, async):
  - cursor = 0, rd_data = 8'h00, frame_dirty = 0, cmd_ready = 0.
  - FSM = CLEARING, clear pointer = 0.
  - Storage is not reset directly; it is cleared by the CLEARING pass.
- FSM states:
  - IDLE: cmd_ready = 1.
  - CLEARING: cmd_ready = 0. Writes CLR_CHAR at the clear pointer each cycle, pointer increments.
  - After the write to address COLS*ROWS-1 (32 cycles), go to IDLE, cursor = 0, frame_dirty = 1.
  - Exception: the post-reset clear ends with frame_dirty = 0.
- Commands are accepted only in IDLE. Every command completes in one cycle.
  - PUT: mem[cursor] = cmd_data; cursor = cursor + 1 (mod COLS*ROWS); frame_dirty = 1.
    - Wrap rules: row0 col15 -> row1 col0; row1 col15 -> row0 col0.
  - SET: cursor = cmd_data[ADDR_W-1:0]; upper bits ignored; no dirty change.
  - HOME: cursor = 0; no dirty change.
  - CLEAR: enter CLEARING on the next cycle; cmd_ready drops on the next cycle.
- Read port:
  - rd_data is registered from mem[rd_addr], 1-cycle latency, always active, including during CLEARING (partially cleared contents visible).
  - Same-cycle read and write to the same address: rd_data returns the old value (read-before-write).
- Dirty flag:
  - frame_ack clears frame_dirty.
  - frame_ack coinciding with a PUT or with CLEARING completion: the set wins, frame_dirty stays 1.
  - frame_ack while frame_dirty = 0: no effect.
- frame_req is held low during CLEARING so the driver never snapshots a half-cleared frame.
- Reset mid-CLEARING or mid-command: state, cursor and dirty return to their reset values, and clearing restarts from address 0.
- Storage is a single-write-port, single-read-port array of COLS*ROWS x 8, inferable as distributed or block RAM.

Decomposition:
- Shared package lcd_pkg holds:
  - cmd_op encodings (OP_PUT, OP_SET, OP_CLEAR, OP_HOME)
  - CHAR_SPACE = 8'h20
  - LCD line base addresses DDRAM_LINE1 = 8'h80 and DDRAM_LINE2 = 8'hC0, shared with the driver
- One sub-module: lcd_char_ram (1W/1R synchronous array, registered read, read-before-write). FSM, cursor and dirty logic stay in the top.

Test Plan:
- Release reset -> cmd_ready = 0 for exactly 32 cycles, then 1. Reads of addresses 0..31 all return 8'h20. frame_dirty = 0, cursor = 0.
- PUT 8'h47, PUT 8'h41 -> rd_addr 0/1 return 8'h47/8'h41 one cycle after the address. cursor = 2. frame_dirty = frame_req = 1. frame_ack pulse -> both 0 the next cycle.
- SET 8'h0F, then PUT 8'h21 twice -> mem[15] = mem[16] = 8'h21, cursor = 17. SET 8'hFF then PUT 8'h58 -> mem[31] = 8'h58, cursor = 0.
- PUT then CLEAR -> cmd_ready low for 32 cycles, frame_req = 0 throughout though frame_dirty = 1. Afterwards all reads 8'h20, cursor = 0, frame_req = 1. frame_ack on the completion cycle -> frame_dirty stays 1.
- frame_ack in the same cycle as a PUT -> frame_dirty remains 1. cmd_valid held during CLEARING -> command not consumed until cmd_ready rises.
- Assert resetn at clear cycle 10 after a CLEAR -> cursor = 0, frame_dirty = 0, a full 32-cycle clear restarts. rd_addr 5 = 8'h20 afterwards.
